// File: rtl/adc_scan_sequencer.sv
// Multi-channel ADC scan sequencer: mux select, settle wait, discard, power-of-two
// averaging and valid/ready hand-off of channel-tagged results with an ADC watchdog.
module adc_scan_sequencer #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CHW      = 2,
    parameter int unsigned SETTLE   = 16,
    parameter int unsigned DISCARD  = 1,
    parameter int unsigned LOG2_AVG = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [NCH-1:0] chan_mask,
    input  logic           clr_err,
    output logic [CHW-1:0] mux_sel,
    output logic           adc_enable,
    input  logic [15:0]    adc_data,
    input  logic           adc_newdata,
    output logic [15:0]    out_data,
    output logic [CHW-1:0] out_chan,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           err_timeout
);

    localparam int unsigned NAVG = 1 << LOG2_AVG;
    localparam int unsigned AW   = 16 + LOG2_AVG;
    localparam int unsigned SW   = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);
    localparam int unsigned NW   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ACQ,
        S_OUTPUT
    } state_t;

    state_t         state_q;
    logic [CHW-1:0] mux_q;
    logic           adc_en_q;
    logic [15:0]    out_data_q;
    logic [CHW-1:0] out_chan_q;
    logic           out_valid_q;
    logic           err_q;
    logic [SW-1:0]  set_cnt_q;
    logic [TW-1:0]  wdog_q;
    logic [NW-1:0]  smp_q;
    logic [AW-1:0]  acc_q;

    logic [AW-1:0]  sum_d;
    logic [15:0]    avg_d;
    logic [CHW-1:0] pick_first_d;
    logic [CHW-1:0] pick_next_d;
    logic           got_first;
    logic           got_next;

    always_comb begin
        sum_d = acc_q + AW'(adc_data);
        avg_d = 16'(sum_d >> LOG2_AVG);
    end

    // Next channel is the lowest set bit above mux_q; with none above, wrap to the lowest set bit.
    always_comb begin
        pick_first_d = '0;
        pick_next_d  = '0;
        got_first    = 1'b0;
        got_next     = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (chan_mask[i] && !got_first) begin
                pick_first_d = CHW'(i);
                got_first    = 1'b1;
            end
            if (chan_mask[i] && !got_next && (i > 32'(mux_q))) begin
                pick_next_d = CHW'(i);
                got_next    = 1'b1;
            end
        end
        if (!got_next) begin
            pick_next_d = pick_first_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mux_q       <= '0;
            adc_en_q    <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            set_cnt_q   <= '0;
            wdog_q      <= '0;
            smp_q       <= '0;
            acc_q       <= '0;
        end else begin
            // A timeout in the same cycle overrides this clear further down.
            if (clr_err) begin
                err_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    adc_en_q <= 1'b0;
                    if (run && (chan_mask != '0)) begin
                        mux_q     <= pick_first_d;
                        set_cnt_q <= '0;
                        smp_q     <= '0;
                        acc_q     <= '0;
                        state_q   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    adc_en_q <= 1'b0;
                    if (set_cnt_q == SW'(SETTLE - 1)) begin
                        adc_en_q <= 1'b1;
                        wdog_q   <= '0;
                        state_q  <= S_ACQ;
                    end else begin
                        set_cnt_q <= set_cnt_q + 1'b1;
                    end
                end
                S_ACQ: begin
                    if (adc_newdata) begin
                        wdog_q <= '0;
                        if (smp_q < NW'(DISCARD)) begin
                            smp_q <= smp_q + 1'b1;
                        end else if (smp_q == NW'(DISCARD + NAVG - 1)) begin
                            out_data_q  <= avg_d;
                            out_chan_q  <= mux_q;
                            out_valid_q <= 1'b1;
                            adc_en_q    <= 1'b0;
                            state_q     <= S_OUTPUT;
                        end else begin
                            acc_q <= sum_d;
                            smp_q <= smp_q + 1'b1;
                        end
                    end else if (wdog_q == TW'(TIMEOUT - 1)) begin
                        err_q    <= 1'b1;
                        adc_en_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    adc_en_q <= 1'b0;
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (run && (chan_mask != '0)) begin
                            mux_q     <= pick_next_d;
                            set_cnt_q <= '0;
                            smp_q     <= '0;
                            acc_q     <= '0;
                            state_q   <= S_SETTLE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mux_sel     = mux_q;
    assign adc_enable  = adc_en_q;
    assign out_data    = out_data_q;
    assign out_chan    = out_chan_q;
    assign out_valid   = out_valid_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a 40-cycle-per-conversion ADC host model.
module tb_adc_scan_sequencer;

    localparam int NCH = 4;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic [NCH-1:0] chan_mask;
    logic           clr_err;
    logic [CHW-1:0] mux_sel;
    logic           adc_enable;
    logic [15:0]    adc_data;
    logic           adc_newdata;
    logic [15:0]    out_data;
    logic [CHW-1:0] out_chan;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           err_timeout;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          adc_mode = 0;   // 0 silent, 1 channel-coded data, 2 sample queue
    int          adc_cnt  = 0;
    logic [15:0] sq[$];

    always #5 clk = ~clk;

    adc_scan_sequencer #(
        .NCH(4), .CHW(2), .SETTLE(16), .DISCARD(1), .LOG2_AVG(2), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .chan_mask(chan_mask), .clr_err(clr_err),
        .mux_sel(mux_sel), .adc_enable(adc_enable), .adc_data(adc_data),
        .adc_newdata(adc_newdata), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .err_timeout(err_timeout)
    );

    // ADC host: one conversion every 40 cycles while enabled, strobes held across one posedge.
    always @(negedge clk) begin
        if (rst === 1'b1 || adc_enable !== 1'b1 || adc_mode == 0) begin
            adc_cnt     = 0;
            adc_newdata = 1'b0;
            if (rst === 1'b1) adc_data = 16'h0;
        end else begin
            adc_cnt = adc_cnt + 1;
            if (adc_cnt == 40) begin
                adc_cnt     = 0;
                adc_newdata = 1'b1;
                if (adc_mode == 1) adc_data = 16'h1000 + {6'd0, mux_sel, 8'h00};
                else adc_data = (sq.size() > 0) ? sq.pop_front() : 16'h0;
            end else begin
                adc_newdata = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
        chan_mask = '0; adc_mode = 0; sq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_enable(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (adc_enable === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; out_ready = 1'b0; clr_err = 1'b0; chan_mask = '0;
        repeat (2) @(negedge clk);
        n_chk++; if (mux_sel !== 2'd0) $display("FAIL reset_mux_sel got %0d want 0", mux_sel); else n_pass++;
        n_chk++; if (adc_enable !== 1'b0) $display("FAIL reset_adc_enable got %b want 0", adc_enable); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (out_data !== 16'h0) $display("FAIL reset_out_data got %h want 0000", out_data); else n_pass++;
        n_chk++; if (out_chan !== 2'd0) $display("FAIL reset_out_chan got %0d want 0", out_chan); else n_pass++;
        n_chk++; if (err_timeout !== 1'b0) $display("FAIL reset_err got %b want 0", err_timeout); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_scan();
        logic [1:0]  exp_ch[4];
        logic [1:0]  nxt;
        logic [15:0] exp_d;
        bit ok;
        int cnt;
        exp_ch = '{2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        chan_mask = 4'b0101; adc_mode = 1; out_ready = 1'b1; run = 1'b1;
        for (int r = 0; r < 4; r++) begin
            exp_d = 16'h1000 + {6'd0, exp_ch[r], 8'h00};
            nxt   = exp_ch[(r + 1) % 4];
            wait_valid(ok);
            n_chk++; if (!ok) $display("FAIL scan_wait_valid r=%0d got timeout want out_valid", r); else n_pass++;
            n_chk++; if (out_chan !== exp_ch[r]) $display("FAIL scan_out_chan r=%0d got %0d want %0d", r, out_chan, exp_ch[r]); else n_pass++;
            n_chk++; if (out_data !== exp_d) $display("FAIL scan_out_data r=%0d got %h want %h", r, out_data, exp_d); else n_pass++;
            @(posedge clk);
            @(negedge clk);
            n_chk++; if (mux_sel !== nxt) $display("FAIL scan_next_mux r=%0d got %0d want %0d", r, mux_sel, nxt); else n_pass++;
            cnt = 0;
            for (int i = 0; i < 100; i++) begin
                if (adc_enable === 1'b1) break;
                cnt++;
                @(negedge clk);
            end
            n_chk++; if (cnt != 16) $display("FAIL scan_settle_len r=%0d got %0d want 16", r, cnt); else n_pass++;
        end
        run = 1'b0;
    endtask

    task automatic test_averaging();
        bit ok;
        do_reset();
        sq = '{16'hFFFF, 16'h0001, 16'h0002, 16'h0003, 16'h0005,
               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        chan_mask = 4'b0001; adc_mode = 2; out_ready = 1'b1; run = 1'b1;
        wait_valid(ok);
        n_chk++; if (!ok) $display("FAIL avg_wait1 got timeout want out_valid"); else n_pass++;
        n_chk++; if (out_data !== 16'h0002) $display("FAIL avg_trunc got %h want 0002", out_data); else n_pass++;
        n_chk++; if (out_chan !== 2'd0) $display("FAIL avg_chan got %0d want 0", out_chan); else n_pass++;
        @(negedge clk);
        wait_valid(ok);
        n_chk++; if (!ok) $display("FAIL avg_wait2 got timeout want out_valid"); else n_pass++;
        n_chk++; if (out_data !== 16'hFFFF) $display("FAIL avg_full_scale got %h want ffff", out_data); else n_pass++;
        run = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        do_reset();
        chan_mask = 4'b0101; adc_mode = 1; out_ready = 1'b0; run = 1'b1;
        wait_valid(ok);
        n_chk++; if (!ok) $display("FAIL bp_wait got timeout want out_valid"); else n_pass++;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid !== 1'b1 || out_data !== 16'h1000 || out_chan !== 2'd0 ||
                adc_enable !== 1'b0 || mux_sel !== 2'd0) bad++;
            @(negedge clk);
        end
        n_chk++; if (bad != 0) $display("FAIL bp_stable got %0d unstable cycles want 0", bad); else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (busy !== 1'b1 || adc_enable !== 1'b0) $display("FAIL bp_release_settle got busy=%b en=%b want busy=1 en=0", busy, adc_enable); else n_pass++;
        n_chk++; if (mux_sel !== 2'd2) $display("FAIL bp_release_mux got %0d want 2", mux_sel); else n_pass++;
        run = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        do_reset();
        chan_mask = 4'b0001; adc_mode = 0; run = 1'b1;
        wait_enable(ok);
        n_chk++; if (!ok) $display("FAIL to_wait_enable got timeout want adc_enable"); else n_pass++;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (err_timeout === 1'b1) break;
        end
        run = 1'b0;
        n_chk++; if (n != 255) $display("FAIL to_cycles got %0d want 255", n); else n_pass++;
        n_chk++; if (adc_enable !== 1'b0) $display("FAIL to_adc_enable got %b want 0", adc_enable); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL to_busy got %b want 0", busy); else n_pass++;
        repeat (5) @(negedge clk);
        n_chk++; if (err_timeout !== 1'b1) $display("FAIL to_sticky got %b want 1", err_timeout); else n_pass++;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_chk++; if (err_timeout !== 1'b0) $display("FAIL to_clear got %b want 0", err_timeout); else n_pass++;
    endtask

    task automatic test_stop_and_empty();
        bit ok;
        int bad;
        do_reset();
        chan_mask = 4'b0101; adc_mode = 1; out_ready = 1'b1; run = 1'b1;
        wait_enable(ok);
        n_chk++; if (!ok) $display("FAIL stop_wait_enable got timeout want adc_enable"); else n_pass++;
        repeat (50) @(negedge clk);
        run = 1'b0;
        wait_valid(ok);
        n_chk++; if (!ok) $display("FAIL stop_wait_valid got timeout want out_valid"); else n_pass++;
        n_chk++; if (out_chan !== 2'd0 || out_data !== 16'h1000) $display("FAIL stop_result got ch=%0d d=%h want ch=0 d=1000", out_chan, out_data); else n_pass++;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL stop_idle got busy=%b valid=%b want 0 0", busy, out_valid); else n_pass++;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        n_chk++; if (bad != 0) $display("FAIL stop_stays_idle got %0d busy cycles want 0", bad); else n_pass++;
        chan_mask = 4'b0000; run = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || adc_enable !== 1'b0) bad++;
        end
        n_chk++; if (bad != 0) $display("FAIL empty_mask_busy got %0d busy cycles want 0", bad); else n_pass++;
        run = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        chan_mask = 4'b0110; adc_mode = 1; out_ready = 1'b1; run = 1'b1;
        wait_enable(ok);
        n_chk++; if (!ok) $display("FAIL ar_wait_enable got timeout want adc_enable"); else n_pass++;
        n_chk++; if (mux_sel !== 2'd1) $display("FAIL ar_first_pick got %0d want 1", mux_sel); else n_pass++;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++; if (mux_sel !== 2'd0) $display("FAIL ar_mux_sel got %0d want 0", mux_sel); else n_pass++;
        n_chk++; if (adc_enable !== 1'b0) $display("FAIL ar_adc_enable got %b want 0", adc_enable); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL ar_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (out_valid !== 1'b0 || err_timeout !== 1'b0) $display("FAIL ar_flags got valid=%b err=%b want 0 0", out_valid, err_timeout); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (mux_sel !== 2'd1 || busy !== 1'b1) $display("FAIL ar_restart got mux=%0d busy=%b want mux=1 busy=1", mux_sel, busy); else n_pass++;
        wait_valid(ok);
        n_chk++; if (!ok) $display("FAIL ar_wait_valid got timeout want out_valid"); else n_pass++;
        n_chk++; if (out_chan !== 2'd1 || out_data !== 16'h1100) $display("FAIL ar_result got ch=%0d d=%h want ch=1 d=1100", out_chan, out_data); else n_pass++;
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_averaging();
        test_backpressure();
        test_timeout();
        test_stop_and_empty();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
